// File: rtl/matrix_alu_sequencer.sv
// Single-instruction sequencer for the 4x4x16 matrix ALU: operand fetch,
// ALU issue, fixed-latency wait and destination write-back.
module matrix_alu_sequencer #(
    parameter int ALU_LATENCY = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         instr_valid,
    input  logic [31:0]  instr,
    output logic         instr_ready,
    output logic         mem_req,
    output logic         mem_we,
    output logic [7:0]   mem_addr,
    output logic [255:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [255:0] mem_rdata,
    output logic [7:0]   alu_opcode,
    output logic [255:0] alu_a,
    output logic [255:0] alu_b,
    output logic         alu_start,
    input  logic [255:0] alu_result,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, EXEC, WAIT, WRITE, DONE, HALT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);

    state_t      state, next_state;
    logic [31:0] instr_q;
    logic [7:0]  tcnt;
    logic [3:0]  wcnt;
    logic        accept;
    logic        op_two, op_one, op_stop;
    logic        req_st, timeout;
    logic        single_src;

    assign accept = instr_valid & instr_ready;

    always_comb begin
        op_two  = 1'b0;
        op_one  = 1'b0;
        op_stop = 1'b0;
        unique case (instr[31:24])
            8'h00, 8'h01, 8'h02, 8'h04: op_two  = 1'b1;
            8'h03, 8'h05:               op_one  = 1'b1;
            8'hFF:                      op_stop = 1'b1;
            default: ;
        endcase
    end

    assign single_src = (instr_q[31:24] == 8'h03) || (instr_q[31:24] == 8'h05);
    assign req_st  = (state == FETCH_A) || (state == FETCH_B) || (state == WRITE);
    // An ack on the final count wins over the timeout
    assign timeout = req_st && !mem_ack && (tcnt == TO_LAST);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept && (op_two || op_one)) next_state = FETCH_A;
                else if (accept && op_stop)       next_state = HALT;
            end
            FETCH_A: begin
                if (mem_ack)      next_state = single_src ? EXEC : FETCH_B;
                else if (timeout) next_state = IDLE;
            end
            FETCH_B: begin
                if (mem_ack)      next_state = EXEC;
                else if (timeout) next_state = IDLE;
            end
            EXEC: next_state = WAIT;
            WAIT: if (wcnt == 4'd0) next_state = WRITE;
            WRITE: begin
                if (mem_ack)      next_state = DONE;
                else if (timeout) next_state = IDLE;
            end
            DONE: next_state = IDLE;
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = req_st;
        mem_we    = (state == WRITE);
        alu_start = (state == EXEC);
        done      = (state == DONE);
        halted    = (state == HALT);
        busy      = (state != IDLE) && (state != HALT);
        mem_addr  = 8'h00;
        unique case (state)
            FETCH_A: mem_addr = instr_q[15:8];
            FETCH_B: mem_addr = instr_q[7:0];
            WRITE:   mem_addr = instr_q[23:16];
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            instr_q     <= '0;
            instr_ready <= 1'b0;
            err         <= 1'b0;
            tcnt        <= '0;
            wcnt        <= '0;
            alu_opcode  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            mem_wdata   <= '0;
        end else begin
            instr_ready <= (next_state == IDLE);
            err <= (accept && !(op_two || op_one || op_stop)) || timeout;
            if (accept) instr_q <= instr;
            if (!req_st || next_state != state) tcnt <= '0;
            else if (!mem_ack)                  tcnt <= tcnt + 8'd1;
            if (state == EXEC)                      wcnt <= WAIT_LAST;
            else if (state == WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
            if (state == FETCH_A && mem_ack) begin
                alu_a <= mem_rdata;
                if (instr_q[31:24] == 8'h03) alu_b <= '0;
                if (instr_q[31:24] == 8'h05) alu_b <= {248'b0, instr_q[7:0]};
            end
            if (state == FETCH_B && mem_ack) alu_b <= mem_rdata;
            if (next_state == EXEC && state != EXEC) alu_opcode <= instr_q[31:24];
            if (state == WAIT && wcnt == 4'd0) mem_wdata <= alu_result;
        end
    end

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Scoreboard bench for matrix_alu_sequencer: memory and ALU models, directed
// instructions, expected writes/done/err queued and checked by a monitor.
module tb_matrix_alu_sequencer;

    localparam int LAT = 2;
    localparam int TO  = 15;

    logic         Clk = 1'b0;
    logic         nReset;
    logic         instr_valid;
    logic [31:0]  instr;
    logic         instr_ready;
    logic         mem_req, mem_we, mem_ack;
    logic [7:0]   mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic [7:0]   alu_opcode;
    logic [255:0] alu_a, alu_b, alu_result;
    logic         alu_start, busy, done, err, halted;

    matrix_alu_sequencer #(.ALU_LATENCY(LAT), .TIMEOUT(TO)) dut (
        .Clk(Clk), .nReset(nReset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_result(alu_result),
        .busy(busy), .done(done), .err(err), .halted(halted)
    );

    always #5 Clk = ~Clk;

    // Memory model with optional wait states and a withheld address
    logic [255:0] mem [0:255];
    bit           withhold;
    logic [7:0]   hold_addr;
    int           ack_wait;
    int           reqcnt;

    always @(posedge Clk) reqcnt <= (mem_req && !mem_ack) ? reqcnt + 1 : 0;
    assign mem_ack = mem_req && !(withhold && mem_addr == hold_addr)
                     && (reqcnt >= ack_wait);
    assign mem_rdata = mem[mem_addr];

    function automatic logic [255:0] alu_f(input logic [7:0] op,
                                           input logic [255:0] a,
                                           input logic [255:0] b);
        logic [255:0] r;
        logic [15:0]  ea, eb;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            ea = a[16*i +: 16];
            eb = b[16*i +: 16];
            case (op)
                8'h01: r[16*i +: 16] = ea + eb;
                8'h02: r[16*i +: 16] = ea - eb;
                8'h03: r[16*i +: 16] = a[16*((i % 4) * 4 + i / 4) +: 16];
                8'h04: r[16*i +: 16] = ea * eb;
                8'h05: r[16*i +: 16] = ea * b[15:0];
                default: r[16*i +: 16] = 16'h0;
            endcase
        end
        return r;
    endfunction

    // Result only valid exactly LAT cycles after the start pulse
    int pend = 0;
    always @(posedge Clk)
        pend <= alu_start ? LAT : (pend != 0 ? pend - 1 : 0);
    assign alu_result = (pend == 1) ? alu_f(alu_opcode, alu_a, alu_b)
                                    : {16{16'hDEAD}};

    typedef struct {
        int           kind;
        logic [7:0]   addr;
        logic [255:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts = 0, reads = 0, req_cycles = 0;
    logic [7:0] last_raddr = 8'h00;

    task automatic push(input int k, input logic [7:0] a, input logic [255:0] d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic pop_check(input int k, input logic [7:0] a, input logic [255:0] d);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d addr %0h, required none", k, a);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL sb_event: got kind %0d addr %0h data %0h, required kind %0d addr %0h data %0h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge Clk) begin
        if (nReset) begin
            if (mem_req && mem_we && mem_ack) pop_check(0, mem_addr, mem_wdata);
            if (done) pop_check(1, 8'h00, '0);
            if (err)  pop_check(2, 8'h00, '0);
            if (alu_start) starts++;
            if (mem_req) req_cycles++;
            if (mem_req && !mem_we && mem_ack) begin
                reads++;
                last_raddr = mem_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] w);
        for (int k = 0; k < 50 && !instr_ready; k++) @(negedge Clk);
        @(negedge Clk);
        instr = w;
        instr_valid = 1'b1;
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {instr_ready, mem_req, mem_we, alu_start, busy, done, err, halted}, '0);
        chk({tag, "_addr"}, {alu_opcode, mem_addr}, '0);
        chk({tag, "_wdata"}, mem_wdata, '0);
        chk({tag, "_ab"}, alu_a | alu_b, '0);
    endtask

    logic [255:0] tr;
    int n, s0, r0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = {16{16'h0003}};
        mem[2] = {16{16'h0004}};
        for (int i = 0; i < 16; i++) mem[4][16*i +: 16] = 16'(i);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tr[16*(r*4+c) +: 16] = 16'(c*4 + r);
        withhold = 1'b0;
        hold_addr = 8'h00;
        ack_wait = 0;
        instr_valid = 1'b0;
        instr = '0;
        nReset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        @(negedge Clk) nReset = 1'b1;
        @(posedge Clk);
        #1;
        chk("ready_after_reset", instr_ready, 1);

        // Madd
        s0 = starts;
        push(0, 8'h03, {16{16'h0007}});
        push(1, 8'h00, '0);
        issue(32'h01030102);
        wait_done(n);
        chk("madd_latency", n, 6);
        chk("madd_starts", starts - s0, 1);
        chk("madd_opcode", alu_opcode, 8'h01);

        // Mtranspose
        r0 = reads;
        push(0, 8'h05, tr);
        push(1, 8'h00, '0);
        issue(32'h03050400);
        wait_done(n);
        chk("tr_latency", n, 5);
        chk("tr_reads", reads - r0, 1);
        chk("tr_raddr", last_raddr, 8'h04);
        chk("tr_alu_b", alu_b, '0);

        // MScaleImm
        r0 = reads;
        push(0, 8'h06, {16{16'h0015}});
        push(1, 8'h00, '0);
        issue(32'h05060107);
        wait_done(n);
        chk("simm_latency", n, 5);
        chk("simm_reads", reads - r0, 1);
        chk("simm_raddr", last_raddr, 8'h01);
        chk("simm_alu_b", alu_b, 256'h7);
        chk("simm_opcode", alu_opcode, 8'h05);

        // One wait state per transfer adds three cycles
        ack_wait = 1;
        push(0, 8'h08, {16{16'h0007}});
        push(1, 8'h00, '0);
        issue(32'h01080102);
        wait_done(n);
        chk("wait_latency", n, 9);
        ack_wait = 0;

        // Illegal opcode
        s0 = req_cycles;
        push(2, 8'h00, '0);
        issue(32'h10010203);
        chk("ill_ready", instr_ready, 1);
        chk("ill_err", err, 1);
        repeat (3) @(posedge Clk);
        #1;
        chk("ill_noreq", req_cycles - s0, 0);
        chk("ill_ready_later", instr_ready, 1);

        // Stop, then ignored instructions, then reset
        issue(32'hFF000000);
        chk("stop_halted", halted, 1);
        chk("stop_ready", {instr_ready, busy}, 0);
        s0 = req_cycles;
        @(negedge Clk);
        instr = 32'h01030102;
        instr_valid = 1'b1;
        repeat (5) @(negedge Clk);
        instr_valid = 1'b0;
        chk("halt_ignored", req_cycles - s0, 0);
        chk("halt_sticky", halted, 1);
        nReset = 1'b0;
        #1;
        chk("halt_cleared", halted, 0);
        @(negedge Clk) nReset = 1'b1;
        @(posedge Clk);
        #1;
        chk("halt_ready", instr_ready, 1);

        // Timeout on FETCH_B
        withhold = 1'b1;
        hold_addr = 8'h02;
        s0 = req_cycles;
        push(2, 8'h00, '0);
        issue(32'h01090102);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge Clk);
            #1;
            if (err) begin
                n = k;
                break;
            end
        end
        chk("to_err_edge", n, 16);
        repeat (2) @(posedge Clk);
        #1;
        chk("to_req_cycles", req_cycles - s0, 16);
        chk("to_req_low", mem_req, 0);
        withhold = 1'b0;
        push(0, 8'h0A, {16{16'h0007}});
        push(1, 8'h00, '0);
        issue(32'h010A0102);
        wait_done(n);
        chk("to_next_latency", n, 6);

        // Reset during WAIT
        issue(32'h010B0102);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (alu_start) begin
                n = k;
                break;
            end
        end
        chk("rw_start_seen", n, 2);
        @(posedge Clk);
        #1;
        chk("rw_busy", busy, 1);
        nReset = 1'b0;
        #1;
        chk_zero("rw_reset");
        @(negedge Clk) nReset = 1'b1;
        push(0, 8'h0C, {16{16'h0007}});
        push(1, 8'h00, '0);
        issue(32'h010C0102);
        wait_done(n);
        chk("rw_next_latency", n, 6);

        repeat (5) @(posedge Clk);
        #1;
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
